// File: rtl/pwm_cfg_sequencer.sv
// Round-robin AXI4-Lite configuration sequencer for the PWM register block.
// Grants one requester at a time, issues a single write and optionally a read-back compare.
module pwm_cfg_sequencer #(
    parameter int unsigned NUM_REQ   = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter bit          VERIFY    = 1'b1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [2*NUM_REQ-1:0]       req_reg,
    input  logic [32*NUM_REQ-1:0]      req_data,
    output logic                       done_valid,
    output logic [$clog2(NUM_REQ)-1:0] done_id,
    output logic                       done_err,
    output logic [31:0]                m_axi_awaddr,
    output logic [2:0]                 m_axi_awprot,
    output logic                       m_axi_awvalid,
    input  logic                       m_axi_awready,
    output logic [31:0]                m_axi_wdata,
    output logic [3:0]                 m_axi_wstrb,
    output logic                       m_axi_wvalid,
    input  logic                       m_axi_wready,
    input  logic [1:0]                 m_axi_bresp,
    input  logic                       m_axi_bvalid,
    output logic                       m_axi_bready,
    output logic [31:0]                m_axi_araddr,
    output logic [2:0]                 m_axi_arprot,
    output logic                       m_axi_arvalid,
    input  logic                       m_axi_arready,
    input  logic [31:0]                m_axi_rdata,
    input  logic [1:0]                 m_axi_rresp,
    input  logic                       m_axi_rvalid,
    output logic                       m_axi_rready
);
    localparam int unsigned IDW = $clog2(NUM_REQ);
    typedef logic [IDW:0] sum_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WRESP,
        S_RADDR,
        S_RDATA,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     data_q, data_d;
    logic            awv_q, awv_d;
    logic            wv_q, wv_d;
    logic            err_q, err_d;

    logic            gnt_found;
    logic [IDW-1:0]  gnt_idx;
    sum_t            cand;
    logic [NUM_REQ-1:0] ready_raw;

    // First requesting index at or after rr_q, wrapping modulo NUM_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = sum_t'(rr_q) + sum_t'(k);
            if (cand >= sum_t'(NUM_REQ)) begin
                cand = cand - sum_t'(NUM_REQ);
            end
            if (!gnt_found && req_valid[cand[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        id_d      = id_q;
        addr_d    = addr_q;
        data_d    = data_q;
        awv_d     = awv_q;
        wv_d      = wv_q;
        err_d     = err_q;
        ready_raw = '0;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    ready_raw[gnt_idx] = 1'b1;
                    id_d    = gnt_idx;
                    addr_d  = BASE_ADDR + {28'd0, req_reg[2*gnt_idx +: 2], 2'b00};
                    data_d  = req_data[32*gnt_idx +: 32];
                    rr_d    = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    err_d   = 1'b0;
                    awv_d   = 1'b1;
                    wv_d    = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // AW and W complete independently; leave only once both are done.
                if (awv_q && m_axi_awready) awv_d = 1'b0;
                if (wv_q && m_axi_wready)   wv_d  = 1'b0;
                if ((!awv_q || m_axi_awready) && (!wv_q || m_axi_wready)) begin
                    state_d = S_WRESP;
                end
            end
            S_WRESP: begin
                if (m_axi_bvalid) begin
                    err_d   = (m_axi_bresp != 2'b00);
                    state_d = (VERIFY && (m_axi_bresp == 2'b00)) ? S_RADDR : S_DONE;
                end
            end
            S_RADDR: begin
                if (m_axi_arready) state_d = S_RDATA;
            end
            S_RDATA: begin
                if (m_axi_rvalid) begin
                    err_d   = (m_axi_rresp != 2'b00) || (m_axi_rdata != data_q);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            awv_q   <= 1'b0;
            wv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            awv_q   <= awv_d;
            wv_q    <= wv_d;
            err_q   <= err_d;
        end
    end

    // State resets to IDLE asynchronously, so the accept pulse is masked while reset is high.
    assign req_ready     = reset ? '0 : ready_raw;
    assign done_valid    = (state_q == S_DONE);
    assign done_id       = id_q;
    assign done_err      = (state_q == S_DONE) && err_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awv_q;
    assign m_axi_wdata   = data_q;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = wv_q;
    assign m_axi_bready  = (state_q == S_WRESP);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = (state_q == S_RADDR);
    assign m_axi_rready  = (state_q == S_RDATA);

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Scoreboard bench for pwm_cfg_sequencer with a behavioural AXI4-Lite PWM register slave.
module tb_pwm_cfg_sequencer;
    localparam int NR = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [NR-1:0]    req_valid, req_ready;
    logic [2*NR-1:0]  req_reg;
    logic [32*NR-1:0] req_data;
    logic             done_valid, done_err;
    logic [1:0]       done_id;
    logic [31:0]      m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [2:0]       m_axi_awprot, m_axi_arprot;
    logic [3:0]       m_axi_wstrb;
    logic             m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [1:0]       m_axi_bresp, m_axi_rresp;
    logic             m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic             m_axi_rvalid, m_axi_rready;

    pwm_cfg_sequencer #(.NUM_REQ(NR), .BASE_ADDR(32'h0000_0000), .VERIFY(1'b1)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_reg(req_reg), .req_data(req_data),
        .done_valid(done_valid), .done_id(done_id), .done_err(done_err),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event not expected or did not occur", name);
    endtask

    typedef struct { int id; bit err; int lat; } exp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    exp_t exp_q[$];
    wr_t  exp_wr[$];
    int   acc_q[$];
    int   cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Requesters: valid while issued count exceeds granted count.
    int          total   [NR];
    int          granted [NR];
    logic [1:0]  rreg    [NR];
    logic [31:0] rdat    [NR];
    initial for (int i = 0; i < NR; i++) begin
        total[i] = 0; granted[i] = 0; rreg[i] = '0; rdat[i] = '0;
    end
    for (genvar gi = 0; gi < NR; gi++) begin : g_req
        assign req_valid[gi]           = (total[gi] != granted[gi]);
        assign req_reg[2*gi +: 2]      = rreg[gi];
        assign req_data[32*gi +: 32]   = rdat[gi];
    end
    always @(posedge clock) begin
        for (int i = 0; i < NR; i++) begin
            if (req_ready[i]) begin
                granted[i] <= granted[i] + 1;
                acc_q.push_back(cyc);
            end
        end
    end

    // AXI4-Lite slave model holding the four PWM registers.
    int          aw_delay  = 0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [1:0]  rresp_cfg = 2'b00;
    logic [31:0] rdata_xor = '0;
    int          ar_count  = 0;
    int          aw_wait;
    logic        have_aw, have_w, s_bvalid, s_rvalid;
    logic [31:0] s_waddr, s_wdata, s_last_waddr, s_rdata;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] mem [4];
    logic        aw_hs, w_hs, ar_hs;
    logic [31:0] cur_waddr, cur_wdata;

    assign m_axi_awready = m_axi_awvalid && (aw_wait >= aw_delay);
    assign m_axi_wready  = m_axi_wvalid;
    assign m_axi_arready = m_axi_arvalid;
    assign aw_hs = m_axi_awvalid && m_axi_awready;
    assign w_hs  = m_axi_wvalid && m_axi_wready;
    assign ar_hs = m_axi_arvalid && m_axi_arready;
    assign cur_waddr = aw_hs ? m_axi_awaddr : s_waddr;
    assign cur_wdata = w_hs ? m_axi_wdata : s_wdata;
    assign m_axi_bvalid = s_bvalid;
    assign m_axi_bresp  = s_bresp;
    assign m_axi_rvalid = s_rvalid;
    assign m_axi_rdata  = s_rdata;
    assign m_axi_rresp  = s_rresp;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            aw_wait <= 0; have_aw <= 1'b0; have_w <= 1'b0;
            s_bvalid <= 1'b0; s_rvalid <= 1'b0; s_bresp <= 2'b00; s_rresp <= 2'b00;
            s_waddr <= '0; s_wdata <= '0; s_last_waddr <= '0; s_rdata <= '0;
            for (int i = 0; i < 4; i++) mem[i] <= '0;
        end else begin
            aw_wait <= (m_axi_awvalid && !m_axi_awready) ? aw_wait + 1 : 0;
            if (aw_hs) begin have_aw <= 1'b1; s_waddr <= m_axi_awaddr; end
            if (w_hs)  begin have_w  <= 1'b1; s_wdata <= m_axi_wdata;  end
            if ((have_aw || aw_hs) && (have_w || w_hs)) begin
                have_aw <= 1'b0; have_w <= 1'b0;
                s_bvalid <= 1'b1; s_bresp <= bresp_cfg;
                s_last_waddr <= cur_waddr;
                if (bresp_cfg == 2'b00) mem[cur_waddr[3:2]] <= cur_wdata;
                if (exp_wr.size() == 0) fail("unexpected_write");
                else begin
                    chk("awaddr", cur_waddr, exp_wr[0].addr);
                    chk("wdata", cur_wdata, exp_wr[0].data);
                    void'(exp_wr.pop_front());
                end
            end
            if (s_bvalid && m_axi_bready) s_bvalid <= 1'b0;
            if (ar_hs) begin
                chk("araddr", m_axi_araddr, s_last_waddr);
                s_rvalid <= 1'b1;
                s_rdata  <= mem[m_axi_araddr[3:2]] ^ rdata_xor;
                s_rresp  <= rresp_cfg;
                ar_count <= ar_count + 1;
            end
            if (s_rvalid && m_axi_rready) s_rvalid <= 1'b0;
        end
    end

    // Completion monitor and held-channel stability checks.
    logic        prev_awv = 1'b0, prev_awhs = 1'b0;
    logic [31:0] prev_awaddr = '0;
    always @(negedge clock) begin
        if (!reset && prev_awv && !prev_awhs && m_axi_awvalid)
            chk("awaddr_stable", m_axi_awaddr, prev_awaddr);
        prev_awv    <= m_axi_awvalid;
        prev_awhs   <= aw_hs;
        prev_awaddr <= m_axi_awaddr;
        if (done_valid) begin
            if (exp_q.size() == 0) fail("unexpected_done");
            else begin
                chk("done_id", 32'(done_id), exp_q[0].id);
                chk("done_err", 32'(done_err), 32'(exp_q[0].err));
                if (exp_q[0].lat != 0) begin
                    if (acc_q.size() == 0) fail("missing_accept");
                    else chk("latency", cyc - acc_q[0], exp_q[0].lat);
                end
                if (acc_q.size() != 0) void'(acc_q.pop_front());
                void'(exp_q.pop_front());
            end
        end
    end

    // Caller is at a negedge; expect_done=0 marks a request that will be abandoned.
    task automatic issue(input int id, input logic [1:0] rg, input logic [31:0] d,
                         input bit err, input int lat, input bit expect_done);
        rreg[id] = rg;
        rdat[id] = d;
        if (expect_done) begin
            exp_q.push_back('{id: id, err: err, lat: lat});
            exp_wr.push_back('{addr: {28'd0, rg, 2'b00}, data: d});
        end
        total[id] = total[id] + 1;
    endtask

    task automatic drain(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clock);
        end
        chk("drain_pending", exp_q.size(), 0);
        repeat (3) @(negedge clock);
    endtask

    task automatic wait_awvalid(input string name);
        int n = 0;
        while (!m_axi_awvalid && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!m_axi_awvalid) fail(name);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        exp_wr.delete();
        acc_q.delete();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        int arc0;
        // Reset values
        repeat (2) @(negedge clock);
        chk("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
                           m_axi_rready, done_valid, done_err}, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_awaddr", m_axi_awaddr, 0);
        chk("rst_araddr", m_axi_araddr, 0);
        chk("rst_wdata", m_axi_wdata, 0);
        chk("rst_done_id", done_id, 0);
        chk("rst_wstrb", m_axi_wstrb, 4'hF);
        chk("rst_prot", {m_axi_awprot, m_axi_arprot}, 0);
        reset = 1'b0;
        @(negedge clock);

        // Single write: requester 0, reg 2 = 3
        issue(0, 2'd2, 32'h0000_0003, 1'b0, 5, 1'b1);
        drain(50);

        // Round-robin from rr_ptr 0 with all requesters valid
        do_reset();
        for (int i = 0; i < NR; i++) issue(i, 2'(i), 32'(i + 1), 1'b0, 5, 1'b1);
        issue(0, 2'd0, 32'd1, 1'b0, 5, 1'b1);
        drain(200);
        for (int i = 0; i < 4; i++) chk("rr_readback", mem[i], 32'(i + 1));

        // Split handshake: AW delayed 3 cycles, W immediate
        aw_delay = 3;
        issue(1, 2'd1, 32'h0000_00A5, 1'b0, 8, 1'b1);
        @(negedge clock);
        wait_awvalid("split_awvalid_timeout");
        chk("split_wvalid_first", m_axi_wvalid, 1);
        @(negedge clock);
        chk("split_wvalid_dropped", m_axi_wvalid, 0);
        for (int i = 0; i < 20; i++) begin
            if (!m_axi_awvalid) break;
            chk("split_bready_early", m_axi_bready, 0);
            @(negedge clock);
        end
        chk("split_bready", m_axi_bready, 1);
        drain(50);
        aw_delay = 0;

        // Write error: no AR may follow
        bresp_cfg = 2'b10;
        arc0 = ar_count;
        issue(2, 2'd3, 32'h0000_0055, 1'b1, 3, 1'b1);
        drain(50);
        chk("werr_no_ar", ar_count, arc0);
        bresp_cfg = 2'b00;

        // Read-back data mismatch, then read-back error response
        rdata_xor = 32'h1;
        issue(3, 2'd0, 32'h0000_1234, 1'b1, 5, 1'b1);
        drain(50);
        rdata_xor = '0;
        rresp_cfg = 2'b11;
        issue(0, 2'd1, 32'h0000_0007, 1'b1, 5, 1'b1);
        drain(50);
        rresp_cfg = 2'b00;

        // Reset while AW is held; rr_ptr returns to 0
        aw_delay = 10;
        issue(0, 2'd0, 32'h0000_0009, 1'b0, 0, 1'b0);
        @(negedge clock);
        wait_awvalid("rstmid_awvalid_timeout");
        reset = 1'b1;
        #1;
        chk("rstmid_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
                              m_axi_rready, done_valid}, 0);
        aw_delay = 0;
        exp_q.delete();
        exp_wr.delete();
        acc_q.delete();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        issue(1, 2'd2, 32'h0000_0011, 1'b0, 5, 1'b0);
        issue(0, 2'd3, 32'h0000_0022, 1'b0, 5, 1'b0);
        exp_q.push_back('{id: 0, err: 1'b0, lat: 5});
        exp_wr.push_back('{addr: 32'hC, data: 32'h22});
        exp_q.push_back('{id: 1, err: 1'b0, lat: 5});
        exp_wr.push_back('{addr: 32'h8, data: 32'h11});
        drain(100);
        chk("final_wr_pending", exp_wr.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
